// File: rtl/cpu_core.sv
// cpu_core: single-cycle MIPS32 integer subset executor with 32x32 regfile and debug read port.
// Optional CPU_CORE_OVF_TRAP_EN suppresses the destination write on signed overflow of add/addi/sub.
module cpu_core #(
  parameter int NREGS = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     Inst,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            illegal,
  output logic            ovf
);
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            illegal_q, illegal_d, ovf_q, ovf_d;
  logic [5:0]      op, funct;
  logic [4:0]      rs, rt, rd, shamt, waddr;
  logic [15:0]     imm;
  logic [XLEN-1:0] a, b, imm_s, imm_z, res, sum_r, sum_i, dif;
  logic            we, legal, ov;
  assign op = Inst[31:26];
  assign rs = Inst[25:21];
  assign rt = Inst[20:16];
  assign rd = Inst[15:11];
  assign shamt = Inst[10:6];
  assign funct = Inst[5:0];
  assign imm = Inst[15:0];
  assign a = regs_q[rs];
  assign b = regs_q[rt];
  assign imm_s = {{16{imm[15]}}, imm};
  assign imm_z = {16'b0, imm};
  assign sum_r = a + b;
  assign sum_i = a + imm_s;
  assign dif = a - b;
  always_comb begin
    res = '0;
    legal = 1'b1;
    ov = 1'b0;
    waddr = rd;
    if (op == 6'b000000) begin
      case (funct)
        6'b100000: begin res = sum_r; ov = (a[31] == b[31]) && (sum_r[31] != a[31]); end
        6'b100001: res = sum_r;
        6'b100010: begin res = dif; ov = (a[31] != b[31]) && (dif[31] != a[31]); end
        6'b100011: res = dif;
        6'b100100: res = a & b;
        6'b100101: res = a | b;
        6'b100110: res = a ^ b;
        6'b100111: res = ~(a | b);
        6'b101010: res = {31'b0, $signed(a) < $signed(b)};
        6'b101011: res = {31'b0, a < b};
        6'b000000: res = b << shamt;
        6'b000010: res = b >> shamt;
        6'b000011: res = $signed(b) >>> shamt;
        default:   legal = 1'b0;
      endcase
    end else begin
      waddr = rt;
      case (op)
        6'b001000: begin res = sum_i; ov = (a[31] == imm_s[31]) && (sum_i[31] != a[31]); end
        6'b001001: res = sum_i;
        6'b001010: res = {31'b0, $signed(a) < $signed(imm_s)};
        6'b001011: res = {31'b0, a < imm_s};
        6'b001100: res = a & imm_z;
        6'b001101: res = a | imm_z;
        6'b001110: res = a ^ imm_z;
        6'b001111: res = {imm, 16'b0};
        default:   legal = 1'b0;
      endcase
    end
`ifdef CPU_CORE_OVF_TRAP_EN
    we = legal && !ov;
`else
    we = legal;
`endif
  end
  always_comb begin
    regs_d = regs_q;
    if (we && waddr != 5'd0) regs_d[waddr] = res;
    regs_d[0] = '0;
    illegal_d = !legal;
    ovf_d = ovf_q | ov;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      illegal_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      illegal_q <= illegal_d;
      ovf_q <= ovf_d;
    end
  end
  assign dbg_data = regs_q[dbg_addr];
  assign illegal = illegal_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed-vector bench for cpu_core with immediate-assertion checks.
module tb_cpu_core;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Inst = '0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  logic        illegal, ovf;
  int          checks = 0;
  int          errors = 0;
  cpu_core dut (
    .clk(clk), .reset(reset), .Inst(Inst), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .illegal(illegal), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [31:0] ins);
    Inst = ins;
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input string tag, input int r, input logic [31:0] exp);
    dbg_addr = 5'(r);
    #1;
    chk(tag, dbg_data, exp);
  endtask
  initial begin
    logic [31:0] r8_exp;
    reset = 1'b1;
    step(32'h0021_0820);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) rd($sformatf("reset_r%0d", i), i, 32'h0);
    chk("reset_illegal", {31'b0, illegal}, 32'h0);
    chk("reset_ovf", {31'b0, ovf}, 32'h0);
    step(32'h2001_0001);
    step(32'h2002_0001);
    step(32'h2000_0005);
    rd("init_r1", 1, 32'h1);
    rd("init_r2", 2, 32'h1);
    rd("r0_zero", 0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(32'h0021_0820);
      step(32'h0021_1020);
    end
    rd("chain_r1", 1, 32'd32);
    rd("chain_r2", 2, 32'd64);
    step(32'h3C03_8000);
    rd("lui_r3", 3, 32'h8000_0000);
    step(32'h3463_FFFF);
    rd("ori_r3", 3, 32'h8000_FFFF);
    step(32'h0061_202A);
    rd("slt_r4", 4, 32'h1);
    step(32'h0061_282B);
    rd("sltu_r5", 5, 32'h0);
    step(32'h0003_3103);
    rd("sra_r6", 6, 32'hF800_0FFF);
    step(32'h0003_5102);
    rd("srl_r10", 10, 32'h0800_0FFF);
    step(32'h0000_5827);
    rd("nor_r11", 11, 32'hFFFF_FFFF);
    step(32'h2C0C_FFFF);
    rd("sltiu_r12", 12, 32'h1);
    step(32'h382D_FFFF);
    rd("xori_r13", 13, 32'h0000_FFDF);
    step(32'h0041_7022);
    rd("sub_r14", 14, 32'd32);
    step(32'h3C07_7FFF);
    step(32'h34E7_FFFF);
    rd("r7_max", 7, 32'h7FFF_FFFF);
    chk("ovf_pre", {31'b0, ovf}, 32'h0);
    step(32'h00E7_4821);
    rd("addu_r9", 9, 32'hFFFF_FFFE);
    chk("addu_no_ovf", {31'b0, ovf}, 32'h0);
    step(32'h00E7_4020);
    chk("add_ovf", {31'b0, ovf}, 32'h1);
`ifdef CPU_CORE_OVF_TRAP_EN
    r8_exp = 32'h0;
`else
    r8_exp = 32'hFFFF_FFFE;
`endif
    rd("add_ovf_r8", 8, r8_exp);
    step(32'h0000_0000);
    chk("ovf_sticky", {31'b0, ovf}, 32'h1);
    step(32'hFC00_0000);
    chk("illegal_op", {31'b0, illegal}, 32'h1);
    rd("illegal_r1", 1, 32'd32);
    step(32'h0000_0000);
    chk("nop_legal", {31'b0, illegal}, 32'h0);
    step(32'h0021_0801);
    chk("illegal_funct", {31'b0, illegal}, 32'h1);
    rd("illegal_funct_r1", 1, 32'd32);
    reset = 1'b1;
    step(32'h0021_0820);
    reset = 1'b0;
    rd("rst_mid_r1", 1, 32'h0);
    chk("rst_mid_ovf", {31'b0, ovf}, 32'h0);
    chk("rst_mid_illegal", {31'b0, illegal}, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
